// File: rtl/ky32_pkg.sv
// Shared KY32 datapath types: word/index typedefs and the register-bank FSM states.
package ky32_pkg;

    localparam int unsigned KY32_WIDTH = 32;
    localparam int unsigned KY32_NREG  = 8;

    typedef logic [2:0]            reg_idx_t;
    typedef logic [KY32_WIDTH-1:0] ky32_word_t;

    typedef enum logic [0:0] {
        RF_IDLE,
        RF_CLEAR
    } rf_state_t;

endpackage

// File: rtl/ky32_regfile8_if.sv
// Register-bank bus: write strobe/data, two read ports and the clear handshake.
interface ky32_regfile8_if
    import ky32_pkg::*;
#(
    parameter int unsigned WIDTH = KY32_WIDTH
);
    logic [KY32_NREG-1:0] wr_sel;
    logic [WIDTH-1:0]     wr_data;
    reg_idx_t             rd_addr_a;
    reg_idx_t             rd_addr_b;
    logic [WIDTH-1:0]     rd_data_a;
    logic [WIDTH-1:0]     rd_data_b;
    logic                 clr_req;
    logic                 clr_busy;
    logic                 clr_done;
    logic                 sel_err;

    modport master (
        output wr_sel, wr_data, rd_addr_a, rd_addr_b, clr_req,
        input  rd_data_a, rd_data_b, clr_busy, clr_done, sel_err
    );

    modport slave (
        input  wr_sel, wr_data, rd_addr_a, rd_addr_b, clr_req,
        output rd_data_a, rd_data_b, clr_busy, clr_done, sel_err
    );

endinterface

// File: rtl/ky32_onehot_chk.sv
// Classifies the decoder write strobe: zero, exactly one-hot, and the encoded index.
module ky32_onehot_chk
    import ky32_pkg::*;
(
    input  logic [KY32_NREG-1:0] sel,
    output logic                 is_onehot,
    output logic                 is_zero,
    output reg_idx_t             idx
);

    always_comb begin
        is_zero   = (sel == '0);
        // Clearing the lowest set bit leaves zero only for a single-bit vector.
        is_onehot = !is_zero && ((sel & (sel - KY32_NREG'(1))) == '0);
        idx       = '0;
        for (int k = 0; k < KY32_NREG; k++) begin
            if (sel[k]) idx = reg_idx_t'(k);
        end
    end

endmodule

// File: rtl/ky32_regfile8.sv
// 8-entry register bank with one-hot writes, two async read ports and sequenced clear.
// Optional write-through bypass on the read ports when KY32_RF_BYPASS_EN is defined.
module ky32_regfile8
    import ky32_pkg::*;
#(
    parameter int unsigned WIDTH = KY32_WIDTH,
    parameter int unsigned DEPTH = KY32_NREG
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ky32_regfile8_if.slave         bus
);

    if (DEPTH != KY32_NREG) begin : g_depth_chk
        $error("ky32_regfile8: DEPTH must equal the decoder width (8)");
    end

    rf_state_t        state_q, state_d;
    reg_idx_t         clr_idx_q, clr_idx_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             wr_en, clr_en;
    logic             is_onehot, is_zero;
    reg_idx_t         wr_idx;
    logic [WIDTH-1:0] mem_q [DEPTH];

    ky32_onehot_chk u_onehot_chk (
        .sel       (bus.wr_sel),
        .is_onehot (is_onehot),
        .is_zero   (is_zero),
        .idx       (wr_idx)
    );

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        wr_en     = 1'b0;
        clr_en    = 1'b0;
        unique case (state_q)
            RF_IDLE: begin
                wr_en = is_onehot;
                err_d = !is_zero && !is_onehot;
                if (bus.clr_req) begin
                    state_d   = RF_CLEAR;
                    clr_idx_d = '0;
                end
            end
            RF_CLEAR: begin
                clr_en    = 1'b1;
                clr_idx_d = clr_idx_q + 3'd1;
                if (clr_idx_q == reg_idx_t'(DEPTH - 1)) begin
                    state_d = RF_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = RF_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RF_IDLE;
            clr_idx_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        end else begin
            if (wr_en)  mem_q[wr_idx]    <= bus.wr_data;
            if (clr_en) mem_q[clr_idx_q] <= '0;
        end
    end

`ifdef KY32_RF_BYPASS_EN
    // wr_en already implies IDLE and a one-hot strobe.
    assign bus.rd_data_a = (wr_en && bus.rd_addr_a == wr_idx) ? bus.wr_data : mem_q[bus.rd_addr_a];
    assign bus.rd_data_b = (wr_en && bus.rd_addr_b == wr_idx) ? bus.wr_data : mem_q[bus.rd_addr_b];
`else
    assign bus.rd_data_a = mem_q[bus.rd_addr_a];
    assign bus.rd_data_b = mem_q[bus.rd_addr_b];
`endif

    assign bus.clr_busy = (state_q == RF_CLEAR);
    assign bus.clr_done = done_q;
    assign bus.sel_err  = err_q;

endmodule
